// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU operation encodings used by both the control
// unit and the execute-stage ALU.
package cpu_pkg;

    localparam int unsigned ALUOP_W = 4;

    localparam logic [ALUOP_W-1:0] ALUOp_Add  = 4'd0;
    localparam logic [ALUOP_W-1:0] ALUOp_Addu = 4'd1;
    localparam logic [ALUOP_W-1:0] ALUOp_Sub  = 4'd2;
    localparam logic [ALUOP_W-1:0] ALUOp_Subu = 4'd3;
    localparam logic [ALUOP_W-1:0] ALUOp_And  = 4'd4;
    localparam logic [ALUOP_W-1:0] ALUOp_Or   = 4'd5;
    localparam logic [ALUOP_W-1:0] ALUOp_Xor  = 4'd6;
    localparam logic [ALUOP_W-1:0] ALUOp_Nor  = 4'd7;
    localparam logic [ALUOP_W-1:0] ALUOp_Sll  = 4'd8;
    localparam logic [ALUOP_W-1:0] ALUOp_Srl  = 4'd9;
    localparam logic [ALUOP_W-1:0] ALUOp_Slt  = 4'd10;
    localparam logic [ALUOP_W-1:0] ALUOp_Sltu = 4'd11;
    localparam logic [ALUOP_W-1:0] ALUOp_Lui  = 4'd12;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and signed-overflow flag for one op.
module alu_core
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [ALUOP_W-1:0] op,
    input  logic [4:0]         shamt,
    output logic [WIDTH-1:0]   result,
    output logic               overflow
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             sign_a;
    logic             sign_b;
    logic             slt_s;
    logic             slt_u;

    assign sum    = a + b;
    assign diff   = a - b;
    assign sign_a = a[WIDTH-1];
    assign sign_b = b[WIDTH-1];
    // Direct comparators, not a subtraction's sign bit, so extreme operands compare exactly
    assign slt_s  = $signed(a) < $signed(b);
    assign slt_u  = a < b;

    // Select the result for the requested op; overflow only for signed add/sub
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (op)
            ALUOp_Add: begin
                result   = sum;
                overflow = (sign_a == sign_b) && (sum[WIDTH-1] != sign_a);
            end
            ALUOp_Addu: result = sum;
            ALUOp_Sub: begin
                result   = diff;
                overflow = (sign_a != sign_b) && (diff[WIDTH-1] != sign_a);
            end
            ALUOp_Subu: result = diff;
            ALUOp_And:  result = a & b;
            ALUOp_Or:   result = a | b;
            ALUOp_Xor:  result = a ^ b;
            ALUOp_Nor:  result = ~(a | b);
            ALUOp_Sll:  result = b << shamt;
            ALUOp_Srl:  result = b >> shamt;
            ALUOp_Slt:  result = {{(WIDTH-1){1'b0}}, slt_s};
            ALUOp_Sltu: result = {{(WIDTH-1){1'b0}}, slt_u};
            ALUOp_Lui:  result = {b[(WIDTH/2)-1:0], {(WIDTH/2){1'b0}}};
            default: begin
                result   = '0;
                overflow = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_unit.sv
// Execute-stage ALU: combinational core followed by the EX/MEM result register.
module alu_unit
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   inA,
    input  logic [WIDTH-1:0]   inB,
    input  logic [ALUOP_W-1:0] ALUOp,
    input  logic [4:0]         shamt,
    output logic [WIDTH-1:0]   out,
    output logic               overFlow
);

    logic [WIDTH-1:0] core_result;
    logic             core_overflow;

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a        (inA),
        .b        (inB),
        .op       (ALUOp),
        .shamt    (shamt),
        .result   (core_result),
        .overflow (core_overflow)
    );

    // Register result and flag every cycle; reset clears them asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out      <= '0;
            overFlow <= 1'b0;
        end else begin
            out      <= core_result;
            overFlow <= core_overflow;
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_alu_unit;
    import cpu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] inA;
    logic [31:0] inB;
    logic [3:0]  ALUOp;
    logic [4:0]  shamt;
    logic [31:0] out;
    logic        overFlow;

    int unsigned n_checks;
    int unsigned n_fails;

    alu_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inA      (inA),
        .inB      (inB),
        .ALUOp    (ALUOp),
        .shamt    (shamt),
        .out      (out),
        .overFlow (overFlow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: integer arithmetic on 64-bit values, range tests for overflow
    function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] sh,
                                  output logic [31:0] r, output logic ov);
        longint sa, sb, ua, ub, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        r  = 32'd0;
        ov = 1'b0;
        case (op)
            4'd0: begin s = sa + sb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd1: begin s = ua + ub; r = s[31:0]; end
            4'd2: begin s = sa - sb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd3: begin s = ua - ub; r = s[31:0]; end
            4'd4: r = a & b;
            4'd5: r = a | b;
            4'd6: r = a ^ b;
            4'd7: r = ~(a | b);
            4'd8: begin s = ub * (64'sd1 <<< sh); r = s[31:0]; end
            4'd9: begin s = ub / (64'sd1 <<< sh); r = s[31:0]; end
            4'd10: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd11: r = (ua < ub) ? 32'd1 : 32'd0;
            4'd12: begin s = (ub % 65536) * 65536; r = s[31:0]; end
            default: begin r = 32'd0; ov = 1'b0; end
        endcase
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One op per cycle: drive on falling edge, sample just after rising edge
    task automatic step(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] exp_out, input logic exp_ov);
        @(negedge clk);
        ALUOp = op; inA = a; inB = b; shamt = sh;
        @(posedge clk);
        #1;
        check32({tag, ".out"}, out, exp_out);
        check1({tag, ".ov"}, overFlow, exp_ov);
    endtask

    task automatic step_model(input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] r;
        logic        ov;
        model(op, a, b, sh, r, ov);
        step($sformatf("rnd op%0d a=%h b=%h sh=%0d", op, a, b, sh), op, a, b, sh, r, ov);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h8000_0000;
            1: v = 32'h7fff_ffff;
            2: v = 32'hffff_ffff;
            3: v = 32'h0000_0000;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n = 1'b0;
        inA = '0; inB = '0; ALUOp = '0; shamt = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check32("reset.out", out, 32'd0);
        check1("reset.ov", overFlow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load a nonzero result with overflow, then reset between edges
        step("pre_reset.add", ALUOp_Add, 32'h7fff_fff0, 32'h10, 5'd0, 32'h8000_0000, 1'b1);
        @(negedge clk);
        ALUOp = ALUOp_Add; inA = 32'd1; inB = 32'd2;
        #1;
        rst_n = 1'b0;
        #1;
        check32("async_reset.out", out, 32'd0);
        check1("async_reset.ov", overFlow, 1'b0);
        @(posedge clk);
        #1;
        check32("reset_hold.out", out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset.add", ALUOp_Add, 32'd1, 32'd2, 5'd0, 32'd3, 1'b0);

        // Opcode sweep, A=0x7ffffff0 B=0x10 shamt=4
        step("sw.add",  ALUOp_Add,  32'h7fff_fff0, 32'h10, 5'd4, 32'h8000_0000, 1'b1);
        step("sw.addu", ALUOp_Addu, 32'h7fff_fff0, 32'h10, 5'd4, 32'h8000_0000, 1'b0);
        step("sw.sub",  ALUOp_Sub,  32'h7fff_fff0, 32'h10, 5'd4, 32'h7fff_ffe0, 1'b0);
        step("sw.subu", ALUOp_Subu, 32'h7fff_fff0, 32'h10, 5'd4, 32'h7fff_ffe0, 1'b0);
        step("sw.and",  ALUOp_And,  32'h7fff_fff0, 32'h10, 5'd4, 32'h0000_0010, 1'b0);
        step("sw.nor",  ALUOp_Nor,  32'h7fff_fff0, 32'h10, 5'd4, 32'h8000_000f, 1'b0);
        step("sw.or",   ALUOp_Or,   32'h7fff_fff0, 32'h10, 5'd4, 32'h7fff_fff0, 1'b0);
        step("sw.xor",  ALUOp_Xor,  32'h7fff_fff0, 32'h10, 5'd4, 32'h7fff_ffe0, 1'b0);
        step("sw.sll",  ALUOp_Sll,  32'h7fff_fff0, 32'h10, 5'd4, 32'h0000_0100, 1'b0);
        step("sw.srl",  ALUOp_Srl,  32'h7fff_fff0, 32'h10, 5'd4, 32'h0000_0001, 1'b0);
        step("sw.slt",  ALUOp_Slt,  32'h7fff_fff0, 32'h10, 5'd4, 32'h0000_0000, 1'b0);
        step("sw.sltu", ALUOp_Sltu, 32'h7fff_fff0, 32'h10, 5'd4, 32'h0000_0000, 1'b0);

        // A=-1, B=1
        step("m1.add",  ALUOp_Add,  32'hffff_ffff, 32'd1, 5'd0, 32'h0000_0000, 1'b0);
        step("m1.addu", ALUOp_Addu, 32'hffff_ffff, 32'd1, 5'd0, 32'h0000_0000, 1'b0);
        step("m1.sub",  ALUOp_Sub,  32'hffff_ffff, 32'd1, 5'd0, 32'hffff_fffe, 1'b0);
        step("m1.slt",  ALUOp_Slt,  32'hffff_ffff, 32'd1, 5'd0, 32'h0000_0001, 1'b0);
        step("m1.sltu", ALUOp_Sltu, 32'hffff_ffff, 32'd1, 5'd0, 32'h0000_0000, 1'b0);
        step("m1.lui",  ALUOp_Lui,  32'hffff_ffff, 32'd1, 5'd0, 32'h0001_0000, 1'b0);

        // Sub overflow and its unsigned twin
        step("subov.sub",  ALUOp_Sub,  32'h8000_0000, 32'd1, 5'd0, 32'h7fff_ffff, 1'b1);
        step("subov.subu", ALUOp_Subu, 32'h8000_0000, 32'd1, 5'd0, 32'h7fff_ffff, 1'b0);

        // Set-less-than at the extremes
        step("sltedge.slt",   ALUOp_Slt,  32'h8000_0000, 32'h7fff_ffff, 5'd0, 32'd1, 1'b0);
        step("sltedge.sltu",  ALUOp_Sltu, 32'h8000_0000, 32'h7fff_ffff, 5'd0, 32'd0, 1'b0);
        step("sltswap.slt",   ALUOp_Slt,  32'h7fff_ffff, 32'h8000_0000, 5'd0, 32'd0, 1'b0);
        step("sltswap.sltu",  ALUOp_Sltu, 32'h7fff_ffff, 32'h8000_0000, 5'd0, 32'd1, 1'b0);

        // Shift boundaries: by 0 passes B, by 31 keeps a single bit
        step("sll0",  ALUOp_Sll, 32'hdead_beef, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0);
        step("srl0",  ALUOp_Srl, 32'hdead_beef, 32'h8765_4321, 5'd0,  32'h8765_4321, 1'b0);
        step("sll31", ALUOp_Sll, 32'h0,         32'h0000_0003, 5'd31, 32'h8000_0000, 1'b0);
        step("srl31", ALUOp_Srl, 32'hffff_ffff, 32'hc000_0000, 5'd31, 32'h0000_0001, 1'b0);

        // Unused opcodes after an overflowing add
        step("pre13.add", ALUOp_Add, 32'h7fff_ffff, 32'd1, 5'd0, 32'h8000_0000, 1'b1);
        step("op13", 4'd13, 32'hffff_ffff, 32'hffff_ffff, 5'd7, 32'd0, 1'b0);
        step("op14", 4'd14, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'd0, 1'b0);
        step("op15", 4'd15, 32'h7fff_ffff, 32'h0000_0001, 5'd3, 32'd0, 1'b0);

        // Random back-to-back ops against the model
        for (int i = 0; i < 300; i++) begin
            step_model(4'($urandom_range(0, 15)), pick_operand(), pick_operand(),
                       5'($urandom_range(0, 31)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
